prv32_branch_resolve: RTL and testbench
=======================================

Name: prv32_branch_resolve

Overview:
Consumes the ALU condition flags (cf, zf, vf, sf) produced for a compare-subtract in EX, together with the branch/jump decode, and resolves the branch. The pipeline uses static not-taken prediction, so every taken branch or jump is a mispredict. For each one, the block issues a registered redirect to fetch using a valid/ready handshake, then flushes the younger stages for a programmable number of cycles. It also keeps saturating branch and mispredict counters.

Parameters:
FLUSH_CYCLES, 2, cycles flush_ifid/flush_idex stay high after the redirect handshake completes (1..15).
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
br_valid  in  1  EX holds a conditional branch or jump this cycle
br_funct3  in  3  branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
is_jal  in  1  instruction is JAL (unconditional)
is_jalr  in  1  instruction is JALR (unconditional)
cf  in  1  ALU carry of a + ~b + 1 (1 = no borrow, a >= b unsigned)
zf  in  1  ALU zero flag
vf  in  1  ALU overflow flag
sf  in  1  ALU sign flag
target  in  32  computed target (pc+imm, or rs1+imm for JALR)
br_accept  out  1  block can accept br_valid this cycle
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  new fetch PC
redirect_ready  in  1  fetch accepts the redirect
flush_ifid  out  1  squash the IF/ID register
flush_idex  out  1  squash the ID/EX register
stall_ex  out  1  hold EX/earlier stages (equals ~br_accept)
branch_count  out  CNT_W  branches/jumps resolved, saturating
mispredict_count  out  CNT_W  taken branches/jumps, saturating

Behaviour:
- Reset (synchronous, on clk rising edge with rst=1; overrides everything, including mid-redirect or mid-flush):
  - state=IDLE; redirect_valid=0, redirect_pc=0, flush_*=0, counters=0, br_accept=1.
- br_accept=1 only in IDLE. br_valid while br_accept=0 is ignored; upstream holds the instruction because stall_ex=1.
- Taken decision (combinational on inputs):
  - taken = is_jal | is_jalr | cond.
  - cond: BEQ zf; BNE ~zf; BLT sf^vf; BGE ~(sf^vf); BLTU ~cf; BGEU cf.
  - funct3 010/011 gives cond=0.
  - If is_jal and is_jalr are both set, treat the instruction as a jump.
- Target: redirect_pc = target, with bit 0 forced to 0 when is_jalr. Bits [1:0] are otherwise passed unchanged; alignment faults are not handled here.
- States:
  - IDLE: on br_valid, branch_count increments (saturating at all-ones).
    - If taken: mispredict_count increments (saturating), redirect_pc is registered, redirect_valid=1 next cycle, and the state moves to REDIRECT. flush_ifid and flush_idex assert in the same next cycle.
    - If not taken: stay in IDLE with no outputs.
  - REDIRECT: redirect_valid and redirect_pc are held stable until redirect_ready=1. On the handshake edge, redirect_valid drops next cycle, the flush counter loads FLUSH_CYCLES, and the state moves to FLUSH. Flushes stay high throughout REDIRECT.
  - FLUSH: flushes stay high. The counter decrements each cycle. When it reaches 1, the next state is IDLE and the flushes deassert together with br_accept rising.
- Latency:
  - br_valid at edge N gives redirect_valid high from N+1.
  - If ready is already high at N+1, flushes last 1+FLUSH_CYCLES cycles and br_accept returns at N+2+FLUSH_CYCLES.
- Counters never wrap; they hold at 2^CNT_W-1.
- FLUSH_CYCLES=0 is illegal; an elaboration-time check is required.

Decomposition:
- Shared package: funct3 branch encodings (BR_BEQ…BR_BGEU), state encoding (IDLE/REDIRECT/FLUSH), and the flag-to-condition function so that the ALU compare path and this block agree on cf polarity.
- One natural sub-module: prv32_sat_counter (CNT_W parameter, inc, rst), instantiated twice.

Test Plan:
- BEQ with zf=1, target=0x0000_0100, redirect_ready=1 -> redirect_valid pulses 1 cycle at N+1 with pc 0x100; flushes high 3 cycles; branch_count=1, mispredict_count=1.
- BNE with zf=1 -> not taken: no redirect, no flush, br_accept stays 1; branch_count=1, mispredict_count=0.
- BLTU a=1, b=2 (cf=0) taken; BGEU same flags not taken; BLT with sf=1, vf=1 not taken -> redirects exactly as listed.
- JALR target=0x0000_2003, redirect_ready held 0 for 4 cycles -> redirect_pc=0x2002 held stable, redirect_valid high 5 cycles, br_valid pulses during this time are ignored, and the counters do not move.
- rst asserted during FLUSH -> next cycle all outputs 0, br_accept=1, counters 0; a following BEQ resolves normally.
- CNT_W=4: 20 taken JALs -> both counters saturate at 15.

Source files
------------

// File: rtl/prv32_branch_resolve_pkg.sv
// Shared definitions for branch resolution: funct3 encodings, the resolver
// state encoding, and the flag-to-condition mapping used by EX.
package prv32_branch_resolve_pkg;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } br_state_t;

   // Maps compare-subtract flags to a branch condition. The carry flag is the
   // carry out of a + ~b + 1, so cf=1 means no borrow, i.e. a >= b unsigned.
   // The ALU compare path must use this same polarity.
   function automatic logic branch_cond(input logic [2:0] funct3,
                                        input logic       cf,
                                        input logic       zf,
                                        input logic       vf,
                                        input logic       sf);
      logic c;
      c = 1'b0;
      case (funct3)
         BR_BEQ:  c = zf;
         BR_BNE:  c = ~zf;
         BR_BLT:  c = sf ^ vf;
         BR_BGE:  c = ~(sf ^ vf);
         BR_BLTU: c = ~cf;
         BR_BGEU: c = cf;
         default: c = 1'b0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/prv32_sat_counter.sv
// Saturating up-counter used for branch statistics; holds at all-ones.
module prv32_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count up on each inc pulse, but never wrap past all-ones so software
   // reading a long-running counter sees a pinned maximum rather than garbage.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/prv32_branch_resolve.sv
// Branch resolver: decides taken/not-taken from ALU flags, redirects fetch on
// every taken branch or jump (static not-taken prediction), then holds the
// younger-stage flushes for a programmable number of cycles.
module prv32_branch_resolve #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_valid,
   input  logic [2:0]       br_funct3,
   input  logic             is_jal,
   input  logic             is_jalr,
   input  logic             cf,
   input  logic             zf,
   input  logic             vf,
   input  logic             sf,
   input  logic [31:0]      target,
   output logic             br_accept,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   input  logic             redirect_ready,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             stall_ex,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   import prv32_branch_resolve_pkg::*;

   if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 15)) begin : g_bad_flush_cycles
      $error("prv32_branch_resolve: FLUSH_CYCLES must be in the range 1..15");
   end

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("prv32_branch_resolve: CNT_W must be at least 1");
   end

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   br_state_t   state;
   br_state_t   state_nxt;
   logic [3:0]  flush_cnt;
   logic [3:0]  flush_cnt_nxt;
   logic [31:0] pc_q;
   logic [31:0] pc_nxt;
   logic        taken;
   logic        accept;
   logic [31:0] resolved_pc;

   // Jumps are always taken; conditional branches follow the shared flag
   // mapping. JALR clears bit 0 of its target; other bits pass untouched.
   always_comb begin
      taken       = is_jal | is_jalr | branch_cond(br_funct3, cf, zf, vf, sf);
      resolved_pc = {target[31:1], target[0] & ~is_jalr};
      accept      = br_valid & (state == IDLE);
   end

   // Next-state logic: IDLE launches a redirect on a taken branch, REDIRECT
   // waits for fetch to take it, FLUSH counts down the squash window.
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      pc_nxt        = pc_q;
      case (state)
         IDLE: begin
            if (accept && taken) begin
               state_nxt = REDIRECT;
               pc_nxt    = resolved_pc;
            end
         end
         REDIRECT: begin
            if (redirect_ready) begin
               state_nxt     = FLUSH;
               flush_cnt_nxt = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            if (flush_cnt <= 4'd1) begin
               state_nxt     = IDLE;
               flush_cnt_nxt = 4'd0;
            end else begin
               flush_cnt_nxt = flush_cnt - 4'd1;
            end
         end
         default: begin
            state_nxt     = IDLE;
            flush_cnt_nxt = 4'd0;
         end
      endcase
   end

   // State, flush countdown and the captured redirect PC. Reset wins over
   // everything, including an in-flight redirect or flush window.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         flush_cnt <= 4'd0;
         pc_q      <= 32'd0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
         pc_q      <= pc_nxt;
      end
   end

   // All handshake and flush outputs decode straight from the registered
   // state, so fetch and the pipeline registers see glitch-free levels.
   always_comb begin
      br_accept      = (state == IDLE);
      stall_ex       = ~br_accept;
      redirect_valid = (state == REDIRECT);
      redirect_pc    = pc_q;
      flush_ifid     = (state != IDLE);
      flush_idex     = (state != IDLE);
   end

   prv32_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (accept),
      .count (branch_count)
   );

   prv32_sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (accept & taken),
      .count (mispredict_count)
   );

endmodule

// File: tb/tb_prv32_branch_resolve.sv
// Self-checking bench for prv32_branch_resolve: directed cases plus random
// branches compared against a comparison-level model of branch semantics.
module tb_prv32_branch_resolve;

   localparam int FLUSH = 2;

   logic        clk;
   logic        rst;
   logic        br_valid;
   logic [2:0]  br_funct3;
   logic        is_jal;
   logic        is_jalr;
   logic        cf, zf, vf, sf;
   logic [31:0] target;
   logic        br_accept;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic        flush_ifid;
   logic        flush_idex;
   logic        stall_ex;
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;

   logic        br_valid4;
   logic        is_jal4;
   logic [31:0] target4;
   logic        br_accept4;
   logic        redirect_valid4;
   logic [31:0] redirect_pc4;
   logic        flush_ifid4;
   logic        flush_idex4;
   logic        stall_ex4;
   logic [3:0]  branch_count4;
   logic [3:0]  mispredict_count4;

   int total;
   int passed;
   int failed;
   int exp_branch;
   int exp_mis;

   prv32_branch_resolve #(.FLUSH_CYCLES(FLUSH), .CNT_W(16)) dut (
      .clk              (clk),
      .rst              (rst),
      .br_valid         (br_valid),
      .br_funct3        (br_funct3),
      .is_jal           (is_jal),
      .is_jalr          (is_jalr),
      .cf               (cf),
      .zf               (zf),
      .vf               (vf),
      .sf               (sf),
      .target           (target),
      .br_accept        (br_accept),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .redirect_ready   (redirect_ready),
      .flush_ifid       (flush_ifid),
      .flush_idex       (flush_idex),
      .stall_ex         (stall_ex),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   prv32_branch_resolve #(.FLUSH_CYCLES(FLUSH), .CNT_W(4)) dut4 (
      .clk              (clk),
      .rst              (rst),
      .br_valid         (br_valid4),
      .br_funct3        (3'b000),
      .is_jal           (is_jal4),
      .is_jalr          (1'b0),
      .cf               (1'b0),
      .zf               (1'b0),
      .vf               (1'b0),
      .sf               (1'b0),
      .target           (target4),
      .br_accept        (br_accept4),
      .redirect_valid   (redirect_valid4),
      .redirect_pc      (redirect_pc4),
      .redirect_ready   (1'b1),
      .flush_ifid       (flush_ifid4),
      .flush_idex       (flush_idex4),
      .stall_ex         (stall_ex4),
      .branch_count     (branch_count4),
      .mispredict_count (mispredict_count4)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference semantics of each branch type, straight from the ISA compare
   // definitions rather than from ALU flags.
   function automatic logic refTaken(input logic [2:0] f3, input logic jal,
                                     input logic jalr, input logic [31:0] a,
                                     input logic [31:0] b);
      logic t;
      t = 1'b0;
      case (f3)
         3'b000:  t = (a == b);
         3'b001:  t = (a != b);
         3'b100:  t = ($signed(a) <  $signed(b));
         3'b101:  t = ($signed(a) >= $signed(b));
         3'b110:  t = (a <  b);
         3'b111:  t = (a >= b);
         default: t = 1'b0;
      endcase
      return t | jal | jalr;
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   // One comparison: counts it, and reports tag/observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Presents a branch to the DUT with ALU flags produced by a - b.
   task automatic applyStimulus(input logic [2:0] f3, input logic jal,
                                input logic jalr, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] tgt);
      logic [32:0] d;
      d         = {1'b0, a} + {1'b0, ~b} + 33'd1;
      br_valid  = 1'b1;
      br_funct3 = f3;
      is_jal    = jal;
      is_jalr   = jalr;
      cf        = d[32];
      zf        = (d[31:0] == 32'd0);
      sf        = d[31];
      vf        = (a[31] ^ b[31]) & (d[31] ^ a[31]);
      target    = tgt;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " br_accept"}, {31'd0, br_accept}, 32'd1);
      checkOutput({tag, " stall_ex"}, {31'd0, stall_ex}, 32'd0);
      checkOutput({tag, " redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
      checkOutput({tag, " flush"}, {30'd0, flush_ifid, flush_idex}, 32'd0);
      checkOutput({tag, " branch_count"}, {16'd0, branch_count}, 32'(exp_branch));
      checkOutput({tag, " mispredict_count"}, {16'd0, mispredict_count}, 32'(exp_mis));
   endtask

   task automatic checkBusy(input string tag, input logic rv, input logic [31:0] pc);
      checkOutput({tag, " redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
      if (rv) checkOutput({tag, " redirect_pc"}, redirect_pc, pc);
      checkOutput({tag, " flush"}, {30'd0, flush_ifid, flush_idex}, 32'd3);
      checkOutput({tag, " br_accept"}, {31'd0, br_accept}, 32'd0);
      checkOutput({tag, " stall_ex"}, {31'd0, stall_ex}, 32'd1);
      checkOutput({tag, " branch_count"}, {16'd0, branch_count}, 32'(exp_branch));
      checkOutput({tag, " mispredict_count"}, {16'd0, mispredict_count}, 32'(exp_mis));
   endtask

   // Full branch transaction; entered and left just after a rising edge with
   // the DUT idle. Extra br_valid pulses while busy must be ignored.
   task automatic runBranch(input string tag, input logic [2:0] f3,
                            input logic jal, input logic jalr,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] tgt, input int rdyDelay);
      logic        expTaken;
      logic [31:0] expPc;
      expTaken = refTaken(f3, jal, jalr, a, b);
      expPc    = jalr ? {tgt[31:1], 1'b0} : tgt;
      applyStimulus(f3, jal, jalr, a, b, tgt);
      redirect_ready = 1'b0;
      @(negedge clk);
      checkOutput({tag, " accept"}, {31'd0, br_accept}, 32'd1);
      @(posedge clk); #1;
      br_valid = 1'b0;
      is_jal   = 1'b0;
      is_jalr  = 1'b0;
      exp_branch = sat(exp_branch + 1, 65535);
      if (expTaken) exp_mis = sat(exp_mis + 1, 65535);
      if (!expTaken) begin
         @(negedge clk);
         checkIdle({tag, " nt"});
      end else begin
         for (int i = 0; i < rdyDelay; i++) begin
            redirect_ready = 1'b0;
            br_valid       = 1'($urandom_range(0, 1));
            is_jal         = 1'b1;
            @(negedge clk);
            checkBusy({tag, " wait"}, 1'b1, expPc);
            @(posedge clk); #1;
         end
         br_valid       = 1'b0;
         is_jal         = 1'b0;
         redirect_ready = 1'b1;
         @(negedge clk);
         checkBusy({tag, " hs"}, 1'b1, expPc);
         @(posedge clk); #1;
         redirect_ready = 1'b0;
         for (int i = 0; i < FLUSH; i++) begin
            br_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkBusy({tag, " flush"}, 1'b0, expPc);
            @(posedge clk); #1;
         end
         br_valid = 1'b0;
         @(negedge clk);
         checkIdle({tag, " done"});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      total = 0; passed = 0; failed = 0;
      exp_branch = 0; exp_mis = 0;
      rst = 1'b1;
      br_valid = 1'b0; br_funct3 = 3'b000; is_jal = 1'b0; is_jalr = 1'b0;
      cf = 1'b0; zf = 1'b0; vf = 1'b0; sf = 1'b0; target = 32'd0;
      redirect_ready = 1'b0;
      br_valid4 = 1'b0; is_jal4 = 1'b0; target4 = 32'd0;

      @(posedge clk); #1;
      @(negedge clk);
      checkIdle("reset");
      checkOutput("reset redirect_pc", redirect_pc, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] directed branches");
      runBranch("beq_taken",   3'b000, 1'b0, 1'b0, 32'd5, 32'd5, 32'h0000_0100, 0);
      runBranch("bne_nt",      3'b001, 1'b0, 1'b0, 32'd9, 32'd9, 32'h0000_0200, 0);
      runBranch("bltu_taken",  3'b110, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0000_0404, 0);
      runBranch("bgeu_nt",     3'b111, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0000_0408, 0);
      runBranch("blt_sv_nt",   3'b100, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0500, 0);
      runBranch("bge_sv",      3'b101, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0502, 1);
      runBranch("f3_010_nt",   3'b010, 1'b0, 1'b0, 32'd3, 32'd3, 32'h0000_0600, 0);
      runBranch("jalr_stall",  3'b000, 1'b0, 1'b1, 32'd1, 32'd2, 32'h0000_2003, 4);
      runBranch("jal_odd",     3'b011, 1'b1, 1'b0, 32'd1, 32'd2, 32'h0000_3003, 0);
      runBranch("jal_jalr",    3'b001, 1'b1, 1'b1, 32'd4, 32'd4, 32'h0000_4005, 2);

      $display("[TB] random branches");
      for (int n = 0; n < 40; n++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         runBranch("rand", f3, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   a, b, $urandom, $urandom_range(0, 3));
      end

      $display("[TB] reset during flush");
      applyStimulus(3'b000, 1'b0, 1'b0, 32'd7, 32'd7, 32'h0000_0300);
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      br_valid = 1'b0;
      @(posedge clk); #1;
      redirect_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rstflush pre flush", {30'd0, flush_ifid, flush_idex}, 32'd3);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_branch = 0;
      exp_mis    = 0;
      @(negedge clk);
      checkIdle("rstflush post");
      checkOutput("rstflush redirect_pc", redirect_pc, 32'd0);
      @(posedge clk); #1;
      runBranch("beq_after_rst", 3'b000, 1'b0, 1'b0, 32'd11, 32'd11, 32'h0000_0100, 0);

      $display("[TB] 4-bit counter saturation");
      for (int n = 0; n < 20; n++) begin
         br_valid4 = 1'b1;
         is_jal4   = 1'b1;
         target4   = $urandom;
         @(posedge clk); #1;
         br_valid4 = 1'b0;
         is_jal4   = 1'b0;
         repeat (2 + FLUSH) @(posedge clk);
         #1;
         @(negedge clk);
         checkOutput("sat br_accept", {31'd0, br_accept4}, 32'd1);
         checkOutput("sat branch_count", {28'd0, branch_count4}, 32'(sat(n + 1, 15)));
         checkOutput("sat mispredict_count", {28'd0, mispredict_count4}, 32'(sat(n + 1, 15)));
         @(posedge clk); #1;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
